// File: rtl/ram_burst_pkg.sv
// Shared types and constants for the burst initiator and its read-return FIFO.
package ram_burst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } burst_state_t;

    localparam int RD_FIFO_DEPTH = 2;
    localparam int RD_CNT_W      = $clog2(RD_FIFO_DEPTH + 1);
    localparam int RD_PTR_W      = $clog2(RD_FIFO_DEPTH);

endpackage

// File: rtl/ram_burst_rd_fifo.sv
// Small synchronous FIFO holding read data returned by the RAM until downstream takes it.
module ram_burst_rd_fifo
    import ram_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [RD_CNT_W-1:0]   count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [RD_FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [RD_PTR_W-1:0]                      wr_ptr;
    logic [RD_PTR_W-1:0]                      rd_ptr;
    logic                                     do_push;
    logic                                     do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != RD_CNT_W'(RD_FIFO_DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + RD_PTR_W'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + RD_PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + RD_CNT_W'(1);
                2'b01:   count <= count - RD_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_burst_master.sv
// Burst command initiator for one port of dual_port_ram: streams write beats in,
// read beats out, absorbing the RAM's registered read latency and rd_ready stalls.
module ram_burst_master
    import ram_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  busy,
    output logic                  done
);

    burst_state_t          state;
    burst_state_t          state_nxt;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH-1:0] beat_cnt;
    logic                  pending;
    logic                  done_r;
    logic                  done_set;
    logic                  beat;
    logic                  issue;
    logic                  last_beat;
    logic                  credit_ok;
    logic                  drain_empty;
    logic                  pop;
    logic [RD_CNT_W-1:0]   fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;

    assign pop       = rd_valid && rd_ready;
    assign rd_valid  = (fifo_count != '0);
    assign rd_data   = fifo_head;
    assign ram_addr  = addr_cnt;
    assign busy      = (state != IDLE);
    assign done      = done_r;
    assign last_beat = (beat_cnt == '0);

    // Room for one more read: FIFO entries plus the in-flight one, after this cycle's pop.
    assign credit_ok = ({1'b0, fifo_count} + {{RD_CNT_W{1'b0}}, pending} + (RD_CNT_W+1)'(1))
                       <= ((RD_CNT_W+1)'(RD_FIFO_DEPTH) + {{RD_CNT_W{1'b0}}, pop});
    // Exit DRAIN in the cycle of the final pop so done lands right after it.
    assign drain_empty = !pending && (fifo_count == RD_CNT_W'(pop));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        ram_we    = 1'b0;
        ram_data  = '0;
        issue     = 1'b0;
        beat      = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_nxt = cmd_write ? WRITE : READ;
            end
            WRITE: begin
                wr_ready = 1'b1;
                ram_we   = wr_valid;
                ram_data = wr_data;
                beat     = wr_valid;
                if (wr_valid && last_beat) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            READ: begin
                issue = credit_ok;
                beat  = credit_ok;
                if (credit_ok && last_beat)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_empty) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt <= '0;
            beat_cnt <= '0;
            pending  <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r  <= done_set;
            pending <= issue;
            if (state == IDLE && cmd_valid) begin
                addr_cnt <= cmd_addr;
                beat_cnt <= cmd_len;
            end else if (beat) begin
                addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
                beat_cnt <= beat_cnt - ADDR_WIDTH'(1);
            end
        end
    end

    ram_burst_rd_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pending),
        .push_data(ram_q),
        .pop      (pop),
        .count    (fifo_count),
        .head     (fifo_head)
    );

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural single-port RAM and a read scoreboard.
module tb_ram_burst_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [5:0] cmd_addr, cmd_len;
    logic [7:0] wr_data;
    logic       wr_valid, wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid, rd_ready;
    logic [5:0] ram_addr;
    logic [7:0] ram_data, ram_q;
    logic       ram_we, busy, done;

    logic [7:0] mem    [64];
    logic [7:0] shadow [64];
    logic       init_ram;
    logic [7:0] sb [$];
    logic [3:0] bp_pat = 4'b1001;

    int cyc = 0;
    int n_tests = 0, n_fail = 0;
    int pops, gaps, first_pop, last_pop, max_cnt;
    int done_cnt = 0, we_cnt = 0, acc_cnt = 0, last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 5);
    endfunction

    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 64; i++) mem[i] <= pat(i);
        end else begin
            if (ram_we) mem[ram_addr] <= ram_data;
            ram_q <= mem[ram_addr];
        end
    end

    ram_burst_master #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on each accepted read beat and records event timing.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (rd_valid && rd_ready) begin
            if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
            else begin
                exp = sb.pop_front();
                chk("rd_data", rd_data, exp);
            end
            if (pops == 0) first_pop = cyc;
            else if (cyc != last_pop + 1) gaps++;
            last_pop = cyc;
            pops++;
        end
        if (done) done_cnt++;
        if (ram_we) we_cnt++;
        if (cmd_valid && cmd_ready) begin
            acc_cnt++;
            last_acc = cyc;
        end
        if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
    end

    task automatic do_read(input logic [5:0] a, input logic [5:0] l, input bit bp, input string tag);
        int acc;
        bit seen;
        pops = 0; gaps = 0; max_cnt = 0;
        for (int i = 0; i <= int'(l); i++) sb.push_back(shadow[6'(a + i)]);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l; rd_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        acc = cyc;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            at_neg();
            if (done) begin seen = 1'b1; break; end
            tick();
            rd_ready = bp ? bp_pat[k % 4] : 1'b1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_beats"}, pops, int'(l) + 1);
        chk({tag, "_done_after_pop"}, cyc - last_pop, 1);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_fifo_max"}, max_cnt <= 2, 1);
        if (!bp) begin
            chk({tag, "_first_latency"}, first_pop - acc, 2);
            chk({tag, "_gaps"}, gaps, 0);
        end
        tick();
    endtask

    initial begin
        int dc0, ac0, wec0;
        bit seen;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b1; init_ram = 1'b1;
        tick(); tick();
        init_ram = 1'b0;
        for (int i = 0; i < 64; i++) shadow[i] = pat(i);
        at_neg();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_data", ram_data, 0);
        chk("rst_rd_data", rd_data, 0);

        // write burst wrapping past the top address
        tick();
        rst = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h3E; cmd_len = 6'd3;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'hA1 + i);
            at_neg();
            chk("wr_addr", ram_addr, 6'(6'h3E + i));
            chk("wr_we", ram_we, 1);
            chk("wr_ready", wr_ready, 1);
            chk("wr_data_out", ram_data, wr_data);
            shadow[6'(6'h3E + i)] = wr_data;
            tick();
        end
        wr_valid = 1'b0;
        at_neg();
        chk("wr_done", done, 1);
        chk("wr_idle_busy", busy, 0);
        chk("wr_idle_ready", cmd_ready, 1);
        chk("mem_3e", mem[6'h3E], 8'hA1);
        chk("mem_3f", mem[6'h3F], 8'hA2);
        chk("mem_00", mem[6'h00], 8'hA3);
        chk("mem_01", mem[6'h01], 8'hA4);
        tick();
        at_neg();
        chk("wr_done_pulse", done, 0);
        tick();

        do_read(6'h3E, 6'd3, 1'b0, "rd_wrap");
        do_read(6'h08, 6'd7, 1'b1, "rd_bp");

        // single-beat write with a 4-cycle gap before data
        wec0 = we_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h10; cmd_len = 6'd0;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("gap_busy", busy, 1);
            chk("gap_we", ram_we, 0);
            tick();
        end
        wr_valid = 1'b1; wr_data = 8'h5C;
        at_neg();
        chk("gap_we_beat", ram_we, 1);
        shadow[6'h10] = 8'h5C;
        tick();
        wr_valid = 1'b0;
        at_neg();
        chk("gap_done", done, 1);
        chk("gap_we_count", we_cnt - wec0, 1);
        chk("gap_mem", mem[6'h10], 8'h5C);
        tick();

        do_read(6'h20, 6'd63, 1'b0, "rd_full");

        // reset while a read burst is stalled with a full FIFO
        dc0 = done_cnt;
        rd_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h00; cmd_len = 6'd5;
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        at_neg();
        chk("pre_rst_rd_valid", rd_valid, 1);
        tick();
        rst = 1'b0; rd_ready = 1'b1;
        at_neg();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rd_valid", rd_valid, 0);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_done", done, 0);
        do_read(6'h3E, 6'd1, 1'b0, "rd_after_rst");
        chk("rst_done_count", done_cnt - dc0, 1);

        // command held valid across a whole burst
        dc0 = done_cnt; ac0 = acc_cnt; pops = 0;
        for (int r = 0; r < 2; r++) begin
            sb.push_back(shadow[6'h3E]);
            sb.push_back(shadow[6'h3F]);
        end
        rd_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h3E; cmd_len = 6'd1;
        tick();
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            at_neg();
            if (done) begin seen = 1'b1; break; end
            tick();
        end
        chk("hold_done1_seen", seen, 1);
        chk("hold_accepts", acc_cnt - ac0, 2);
        chk("hold_accept_at_done", last_acc, cyc);
        tick();
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            at_neg();
            if (done) begin seen = 1'b1; break; end
            tick();
        end
        chk("hold_done2_seen", seen, 1);
        chk("hold_beats", pops, 4);
        chk("hold_sb_empty", sb.size(), 0);
        chk("hold_done_count", done_cnt - dc0, 2);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Command-driven initiator for one port (A or B) of the team's `dual_port_ram`. It accepts a burst command (direction, start address, length) and streams write data into the RAM or streams read data out of it over valid/ready interfaces. It handles the RAM's one-cycle registered read latency and downstream backpressure internally. Instantiate one per RAM port when a client needs burst access instead of raw address/we control.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: RAM word width; must match the attached RAM.
- `ADDR_WIDTH`, default 6: RAM address width; the RAM holds 2**ADDR_WIDTH words.

Ports:
- `clk`  in  1: single clock, shared with the RAM.
- `rst`  in  1: reset, synchronous and active-high.
- `cmd_valid`  in  1: command request.
- `cmd_ready`  out  1: high only in IDLE.
- `cmd_write`  in  1: 1 means write burst, 0 means read burst.
- `cmd_addr`  in  ADDR_WIDTH: start address.
- `cmd_len`  in  ADDR_WIDTH: number of beats minus 1.
- `wr_data`  in  DATA_WIDTH: write beat data.
- `wr_valid`  in  1: write beat present.
- `wr_ready`  out  1: write beat accepted.
- `rd_data`  out  DATA_WIDTH: read beat data.
- `rd_valid`  out  1: read beat present.
- `rd_ready`  in  1: downstream accepts the read beat.
- `ram_addr`  out  ADDR_WIDTH: connects to the RAM `addr_a` or `addr_b` port.
- `ram_data`  out  DATA_WIDTH: connects to the RAM `data_a` or `data_b` port.
- `ram_we`  out  1: connects to the RAM `we_a` or `we_b` port.
- `ram_q`  in  DATA_WIDTH: connects to the RAM `q_a` or `q_b` port.
- `busy`  out  1: high whenever the state is not IDLE.
- `done`  out  1: one-cycle pulse at burst completion.

## Operation
- **States:** IDLE, WRITE, READ, DRAIN.
- **Command accept:** a command is taken when `cmd_valid && cmd_ready`.
  - The block latches the address counter as `cmd_addr` and the beat counter as `cmd_len`.
  - Next state is WRITE if `cmd_write`, otherwise READ.
- **Address counter:** increments by 1 per beat, modulo 2**ADDR_WIDTH. It wraps from the top address to 0.
- **Burst length:** `cmd_len` = 2**ADDR_WIDTH−1 gives a full-memory burst.
- **WRITE state:**
  - `wr_ready` = 1.
  - `ram_we` = `wr_valid`, combinational.
  - `ram_data` = `wr_data`.
  - `ram_addr` = address counter.
  - Each accepted beat advances both counters.
  - On the last beat, go to IDLE and pulse `done` in the following cycle.
- **READ state:**
  - `ram_we` = 0 in every state except WRITE.
  - A read is issued (`ram_addr` = counter, counters advance) only while `fifo_count + pending − pop + 1 ≤ 2`.
    - `pending` is the one-bit flag for an issued read whose `ram_q` is not yet captured.
    - `pop` = `rd_valid && rd_ready`.
  - In the cycle after an issue, `ram_q` is pushed into the 2-entry output FIFO.
  - After the last issue, go to DRAIN.
- **DRAIN state:** wait until `pending` = 0 and the FIFO is empty. Then go to IDLE and pulse `done` in the following cycle.
- **Read output:** `rd_valid` = FIFO non-empty; `rd_data` = FIFO head. Data is returned in address order.
- **Overlapping commands:** commands are not accepted while busy; `cmd_ready` = 0 outside IDLE.
- **Reset mid-burst:**
  - State returns to IDLE, the FIFO and `pending` are cleared, and in-flight reads are discarded.
  - The remaining beats are abandoned; RAM contents already written are kept.
- **Reset values:** `cmd_ready` = 1, `busy` = 0, `done` = 0, `wr_ready` = 0, `rd_valid` = 0, `ram_we` = 0, `ram_addr` = 0, `ram_data` = 0, `rd_data` = 0.

## Timing
- **Command to first beat:** command accepted at edge 0; WRITE/READ is active from cycle 1.
- **Write:**
  - A beat presented in cycle t is written to the RAM at the end of cycle t.
  - Throughput is 1 beat/cycle while `wr_valid` = 1.
- **Read:**
  - Issue in cycle t; `ram_q` is valid in t+1; pushed into the FIFO at the end of t+1; `rd_valid` rises in t+2.
  - Read latency from issue is 2 cycles.
- **Throughput:** with `rd_ready` held at 1, the block sustains 1 beat/cycle after the first.
- **Backpressure:** `rd_ready` = 0 stalls issue within 1 cycle. The FIFO never overflows; a push to a full FIFO is a bench-checked error.
- **`done` timing:** high exactly one cycle.
  - Write: asserted in the cycle after the last write beat.
  - Read: asserted in the cycle after the last pop.
- **Back-to-back commands:** a new command can be accepted in the same cycle `done` is high, because the state is already IDLE.

## Structure
- **Shared package `ram_burst_pkg`:**
  - State enum (IDLE, WRITE, READ, DRAIN).
  - Constant `RD_FIFO_DEPTH` = 2.
- **Sub-module `ram_burst_rd_fifo`:** 2-entry synchronous FIFO with push, pop, count, head and the same synchronous `rst`.
- **Top level:** the state machine, counters, `pending` flag and issue-credit logic.

## Test plan
- **Write then read:** write burst at address 0x3E, len 3, data 0xA1..0xA4 → RAM[0x3E, 0x3F, 0x00, 0x01] = A1..A4 (covers wrap-around). Then read the same burst with `rd_ready`=1 → `rd_data` A1, A2, A3, A4 on consecutive cycles, first beat 3 cycles after command accept, `done` one cycle after the last pop.
- **Read backpressure:** read len 7 with `rd_ready` toggling 1,0,0,1 → no beat lost or duplicated, order preserved, the FIFO never exceeds 2 entries.
- **Gapped write:** write len 0 (single beat) of 0x5C at 0x10 with `wr_valid` delayed 4 cycles → `ram_we` high for exactly one cycle, `done` follows, `busy` stays high through the gap.
- **Full-memory read:** read with `cmd_len` = 63 from 0x20 → 64 beats, addresses 0x20..0x3F then 0x00..0x1F.
- **Reset mid-burst:** assert `rst` for 1 cycle during beat 2 of a len-5 read → next cycle IDLE, `rd_valid`=0, `cmd_ready`=1, no `done` pulse. A new command issued immediately afterwards completes normally.
- **Command while busy:** hold `cmd_valid`=1 for the whole of a burst → the second command is accepted only in the first IDLE cycle (the `done` cycle).
